// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C target controller.
package i2c_slave_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam logic        ACK        = 1'b0;
  localparam logic        NACK       = 1'b1;
  localparam logic [7:0]  FILL_BYTE  = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } state_t;

endpackage

// File: rtl/i2c_slave_ctrl_sync.sv
// SCL/SDA synchronizer with registered edge, START and STOP detection.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_sync
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic r_scl_d, r_sda_d;
  logic r_scl_rise, r_scl_fall, r_start_det, r_stop_det;
  logic w_scl, w_sda;

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  // Idle bus is high, so reset the chain high to avoid a phantom edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_sync  <= '1;
      r_sda_sync  <= '1;
      r_scl_d     <= 1'b1;
      r_sda_d     <= 1'b1;
      r_scl_rise  <= 1'b0;
      r_scl_fall  <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
    end else begin
      r_scl_sync  <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync  <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_d     <= w_scl;
      r_sda_d     <= w_sda;
      r_scl_rise  <= w_scl & ~r_scl_d;
      r_scl_fall  <= ~w_scl & r_scl_d;
      r_start_det <= w_scl & r_scl_d & r_sda_d & ~w_sda;
      r_stop_det  <= w_scl & r_scl_d & ~r_sda_d & w_sda;
    end
  end

  assign scl_rise  = r_scl_rise;
  assign scl_fall  = r_scl_fall;
  assign start_det = r_start_det;
  assign stop_det  = r_stop_det;
  assign sda_sync  = r_sda_d;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C target controller: 7-bit address match, byte write delivery and byte read supply.
module i2c_slave_ctrl
  import i2c_slave_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h68,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic       pclk,
  input  logic       areset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_underrun,
  output logic       busy
);

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (pclk),
    .rst       (areset),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start),
    .stop_det  (w_stop),
    .sda_sync  (w_sda)
  );

  state_t     r_state, w_state_nx;
  logic [7:0] r_shift, w_shift_nx;
  logic [2:0] r_cnt, w_cnt_nx;
  logic       r_rw, w_rw_nx;
  logic       r_first, w_first_nx;
  logic       r_sda_oe, w_oe_nx;
  logic       r_busy, w_busy_nx;
  logic [7:0] r_rx_data, w_rx_data_nx;
  logic       r_rx_valid, w_rx_valid_nx;
  logic       r_rx_first, w_rx_first_nx;
  logic       r_tx_ready, w_tx_ready_nx;
  logic       r_tx_underrun, w_tx_underrun_nx;
  logic       w_load;
  logic [7:0] w_byte;

  assign w_byte = {r_shift[6:0], w_sda};

  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      r_state       <= ST_IDLE;
      r_shift       <= '0;
      r_cnt         <= '0;
      r_rw          <= 1'b0;
      r_first       <= 1'b0;
      r_sda_oe      <= 1'b0;
      r_busy        <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_rx_first    <= 1'b0;
      r_tx_ready    <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_shift       <= w_shift_nx;
      r_cnt         <= w_cnt_nx;
      r_rw          <= w_rw_nx;
      r_first       <= w_first_nx;
      r_sda_oe      <= w_oe_nx;
      r_busy        <= w_busy_nx;
      r_rx_data     <= w_rx_data_nx;
      r_rx_valid    <= w_rx_valid_nx;
      r_rx_first    <= w_rx_first_nx;
      r_tx_ready    <= w_tx_ready_nx;
      r_tx_underrun <= w_tx_underrun_nx;
    end
  end

  always_comb begin
    w_state_nx       = r_state;
    w_shift_nx       = r_shift;
    w_cnt_nx         = r_cnt;
    w_rw_nx          = r_rw;
    w_first_nx       = r_first;
    w_oe_nx          = r_sda_oe;
    w_busy_nx        = r_busy;
    w_rx_data_nx     = r_rx_data;
    w_rx_valid_nx    = 1'b0;
    w_rx_first_nx    = 1'b0;
    w_tx_ready_nx    = 1'b0;
    w_tx_underrun_nx = 1'b0;
    w_load           = 1'b0;

    if (w_stop) begin
      w_state_nx = ST_IDLE;
      w_oe_nx    = 1'b0;
      w_busy_nx  = 1'b0;
    end else if (w_start) begin
      w_state_nx = ST_ADDR;
      w_cnt_nx   = '0;
      w_oe_nx    = 1'b0;
    end else begin
      // ACK states use the current sda_oe to tell the driving fall from the releasing fall.
      unique case (r_state)
        ST_IDLE: ;
        ST_ADDR: if (w_scl_rise) begin
          w_shift_nx = w_byte;
          w_cnt_nx   = r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            if (w_byte[7:1] == SLAVE_ADDR) begin
              w_state_nx = ST_ADDR_ACK;
              w_rw_nx    = w_byte[0];
              w_busy_nx  = 1'b1;
            end else begin
              w_state_nx = ST_WAIT_STOP;
            end
          end
        end
        ST_ADDR_ACK: if (w_scl_fall) begin
          if (!r_sda_oe) begin
            w_oe_nx = 1'b1;
          end else if (r_rw) begin
            w_load = 1'b1;
          end else begin
            w_oe_nx    = 1'b0;
            w_first_nx = 1'b1;
            w_state_nx = ST_WR_DATA;
          end
        end
        ST_WR_DATA: if (w_scl_rise) begin
          w_shift_nx = w_byte;
          w_cnt_nx   = r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            w_rx_data_nx  = w_byte;
            w_rx_valid_nx = 1'b1;
            w_rx_first_nx = r_first;
            w_first_nx    = 1'b0;
            w_state_nx    = ST_WR_ACK;
          end
        end
        ST_WR_ACK: if (w_scl_fall) begin
          if (!r_sda_oe) begin
            w_oe_nx = ACK == 1'b0;
          end else begin
            w_oe_nx    = 1'b0;
            w_state_nx = ST_WR_DATA;
          end
        end
        ST_RD_DATA: begin
          if (w_scl_rise) begin
            w_cnt_nx = r_cnt + 3'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == 3'd0) begin
              w_oe_nx    = 1'b0;
              w_state_nx = ST_RD_ACK;
            end else begin
              w_shift_nx = {r_shift[6:0], 1'b0};
              w_oe_nx    = ~r_shift[6];
            end
          end
        end
        ST_RD_ACK: begin
          if (w_scl_rise && w_sda == NACK) begin
            w_state_nx = ST_WAIT_STOP;
          end else if (w_scl_fall) begin
            w_load = 1'b1;
          end
        end
        ST_WAIT_STOP: ;
        default: w_state_nx = ST_IDLE;
      endcase

      if (w_load) begin
        if (tx_valid) begin
          w_shift_nx    = tx_data;
          w_tx_ready_nx = 1'b1;
        end else begin
          w_shift_nx       = FILL_BYTE;
          w_tx_underrun_nx = 1'b1;
        end
        w_oe_nx    = ~w_shift_nx[7];
        w_cnt_nx   = '0;
        w_state_nx = ST_RD_DATA;
      end
    end
  end

  assign sda_oe      = r_sda_oe & ~areset;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign rx_first    = r_rx_first;
  assign tx_ready    = r_tx_ready;
  assign tx_underrun = r_tx_underrun;
  assign busy        = r_busy;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench for i2c_slave_ctrl: a bit-level I2C master drives the bus wires.
module tb_i2c_slave_ctrl;
  import i2c_slave_pkg::*;

  localparam int unsigned HP = 40;

  logic       pclk = 1'b0;
  logic       areset = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe, rx_valid, rx_first, tx_ready, tx_underrun, busy;
  logic [7:0] rx_data;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_ctrl #(.SLAVE_ADDR(7'h68), .SYNC_STAGES(2)) dut (
    .pclk        (pclk),
    .areset      (areset),
    .scl_i       (scl),
    .sda_i       (sda_bus),
    .sda_oe      (sda_oe),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_first    (rx_first),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_underrun (tx_underrun),
    .busy        (busy)
  );

  always #5 pclk = ~pclk;

  int unsigned n_rxv = 0, n_txr = 0, n_und = 0, n_oe = 0;
  logic [8:0]  rx_log[$];

  always @(negedge pclk) begin
    if (rx_valid) begin
      n_rxv <= n_rxv + 1;
      rx_log.push_back({rx_first, rx_data});
    end
    if (tx_ready)    n_txr <= n_txr + 1;
    if (tx_underrun) n_und <= n_und + 1;
    if (sda_oe)      n_oe  <= n_oe + 1;
  end

  int n_checks = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic bit_io(input logic b, output logic s);
    sda_m = b;
    tick(HP/2);
    scl = 1'b1;
    tick(HP/2);
    s = sda_bus;
    tick(HP/2);
    scl = 1'b0;
    tick(HP/2);
  endtask

  task automatic xfer_byte(input logic [7:0] wr, input logic mack,
                           output logic [7:0] rd, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_io(wr[i], s);
      rd[i] = s;
    end
    bit_io(mack, ack);
  endtask

  task automatic bus_start;
    sda_m = 1'b1;
    scl = 1'b1;
    tick(HP);
    sda_m = 1'b0;
    tick(HP);
    scl = 1'b0;
    tick(HP/2);
  endtask

  task automatic bus_rstart;
    sda_m = 1'b1;
    tick(HP/2);
    scl = 1'b1;
    tick(HP/2);
    sda_m = 1'b0;
    tick(HP/2);
    scl = 1'b0;
    tick(HP/2);
  endtask

  task automatic bus_stop;
    sda_m = 1'b0;
    tick(HP/2);
    scl = 1'b1;
    tick(HP);
    sda_m = 1'b1;
    tick(HP);
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        match;
    int unsigned exp_rx;
  } wvec_t;

  wvec_t tbl[6];

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rd;
    logic        ack;
    int unsigned rx0, tx0, un0, oe0, base;
    logic        seen;

    tbl[0] = '{8'hD0, 8'hA5, 8'h3C, 1'b1, 2};
    tbl[1] = '{8'h84, 8'h12, 8'h34, 1'b0, 0};
    tbl[2] = '{8'hD0, 8'h00, 8'hFF, 1'b1, 2};
    tbl[3] = '{8'hD2, 8'h55, 8'hAA, 1'b0, 0};
    tbl[4] = '{8'h50, 8'h68, 8'hD0, 1'b0, 0};
    tbl[5] = '{8'hD0, 8'h80, 8'h01, 1'b1, 2};

    tick(5);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_pulses", 32'({rx_valid, rx_first, tx_ready, tx_underrun}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    areset = 1'b0;
    tick(10);

    for (int v = 0; v < 6; v++) begin
      rx0 = n_rxv; oe0 = n_oe; base = rx_log.size();
      bus_start;
      xfer_byte(tbl[v].addr, 1'b1, rd, ack);
      check($sformatf("v%0d_addr_ack", v), 32'(ack), 32'(!tbl[v].match));
      xfer_byte(tbl[v].d0, 1'b1, rd, ack);
      check($sformatf("v%0d_d0_ack", v), 32'(ack), 32'(!tbl[v].match));
      xfer_byte(tbl[v].d1, 1'b1, rd, ack);
      check($sformatf("v%0d_d1_ack", v), 32'(ack), 32'(!tbl[v].match));
      check($sformatf("v%0d_busy_pre", v), 32'(busy), 32'(tbl[v].match));
      bus_stop;
      check($sformatf("v%0d_busy_post", v), 32'(busy), 32'd0);
      check($sformatf("v%0d_state", v), 32'(dut.r_state), 32'(ST_IDLE));
      check($sformatf("v%0d_rx_count", v), n_rxv - rx0, tbl[v].exp_rx);
      if (tbl[v].match) begin
        if (rx_log.size() >= base + 2) begin
          check($sformatf("v%0d_rx0", v), 32'(rx_log[base]), 32'({1'b1, tbl[v].d0}));
          check($sformatf("v%0d_rx1", v), 32'(rx_log[base+1]), 32'({1'b0, tbl[v].d1}));
        end
        check($sformatf("v%0d_rx_data", v), 32'(rx_data), 32'(tbl[v].d1));
      end else begin
        check($sformatf("v%0d_oe_cycles", v), n_oe - oe0, 32'd0);
      end
    end

    // Read 0x5A, master NACKs.
    tx_valid = 1'b1; tx_data = 8'h5A; tx0 = n_txr;
    bus_start;
    xfer_byte(8'hD1, 1'b1, rd, ack);
    check("rd_addr_ack", 32'(ack), 32'd0);
    xfer_byte(8'hFF, NACK, rd, ack);
    check("rd_byte", 32'(rd), 32'h5A);
    check("rd_tx_ready", n_txr - tx0, 32'd1);
    check("rd_wait_stop", 32'(dut.r_state), 32'(ST_WAIT_STOP));
    check("rd_released", 32'(sda_oe), 32'd0);
    bus_stop;
    check("rd_busy_post", 32'(busy), 32'd0);

    // Underrun: no tx data available.
    tx_valid = 1'b0; tx0 = n_txr; un0 = n_und;
    bus_start;
    xfer_byte(8'hD1, 1'b1, rd, ack);
    check("un_addr_ack", 32'(ack), 32'd0);
    xfer_byte(8'hFF, NACK, rd, ack);
    check("un_byte", 32'(rd), 32'hFF);
    check("un_pulses", n_und - un0, 32'd1);
    check("un_tx_ready", n_txr - tx0, 32'd0);
    bus_stop;

    // Write 0x11, repeated START, read 0x01 (ACK) and 0x02 (NACK).
    tx_valid = 1'b1; tx_data = 8'h01; tx0 = n_txr; rx0 = n_rxv;
    bus_start;
    xfer_byte(8'hD0, 1'b1, rd, ack);
    check("rs_waddr_ack", 32'(ack), 32'd0);
    xfer_byte(8'h11, 1'b1, rd, ack);
    check("rs_wdata_ack", 32'(ack), 32'd0);
    bus_rstart;
    xfer_byte(8'hD1, 1'b1, rd, ack);
    check("rs_raddr_ack", 32'(ack), 32'd0);
    tx_data = 8'h02;
    xfer_byte(8'hFF, ACK, rd, ack);
    check("rs_rd0", 32'(rd), 32'h01);
    xfer_byte(8'hFF, NACK, rd, ack);
    check("rs_rd1", 32'(rd), 32'h02);
    bus_stop;
    check("rs_rx_data", 32'(rx_data), 32'h11);
    check("rs_rx_count", n_rxv - rx0, 32'd1);
    check("rs_tx_ready", n_txr - tx0, 32'd2);
    check("rs_busy_post", 32'(busy), 32'd0);

    // Async reset while the target drives a zero data bit.
    tx_data = 8'h00;
    bus_start;
    xfer_byte(8'hD1, 1'b1, rd, ack);
    check("ar_addr_ack", 32'(ack), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (sda_oe) seen = 1'b1;
      else tick(1);
    end
    check("ar_oe_driving", 32'(seen), 32'd1);
    #2 areset = 1'b1;
    #1 check("ar_oe_async", 32'(sda_oe), 32'd0);
    tick(3);
    check("ar_state", 32'(dut.r_state), 32'(ST_IDLE));
    check("ar_busy", 32'(busy), 32'd0);
    areset = 1'b0;
    sda_m = 1'b1;
    tick(HP);
    scl = 1'b1;
    tick(HP);
    base = rx_log.size();
    bus_start;
    xfer_byte(8'hD0, 1'b1, rd, ack);
    check("ar_post_addr_ack", 32'(ack), 32'd0);
    xfer_byte(8'h77, 1'b1, rd, ack);
    check("ar_post_data_ack", 32'(ack), 32'd0);
    bus_stop;
    check("ar_post_rx_count", rx_log.size() - base, 32'd1);
    check("ar_post_rx_data", 32'(rx_data), 32'h77);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave_ctrl.md
# i2c_slave_ctrl

Synthesizable I2C target (slave) controller. It responds to the transactions the I2C master agent drives on the shared `i2c_if` bus. It decodes START, STOP and repeated START, matches a 7-bit address, ACKs, and delivers written bytes on a byte-wide receive port. Read data comes from a byte-wide transmit port. It sits on the bus wires as the RTL counterpart to the slave agent BFM and is clocked by the system clock `pclk`.

## Interface
- `SLAVE_ADDR`, default 7'h68: 7-bit address the block responds to.
- `SYNC_STAGES`, default 2: synchronizer flops on `scl_i`/`sda_i`; minimum 2.
- `pclk` in 1: system clock; all logic is on the rising edge.
- `areset` in 1: asynchronous, active-high reset.
- `scl_i` in 1: SCL wire level. The block is SCL-input only; it never stretches the clock.
- `sda_i` in 1: SDA wire level.
- `sda_oe` out 1: 1 pulls SDA low; 0 releases SDA (open-drain).
- `rx_data` out 8: last received write byte.
- `rx_valid` out 1: one-cycle pulse when `rx_data` is updated.
- `rx_first` out 1: high with `rx_valid` for the first data byte after the address.
- `tx_data` in 8: next read byte.
- `tx_valid` in 1: `tx_data` is available.
- `tx_ready` out 1: one-cycle pulse when `tx_data` is consumed.
- `tx_underrun` out 1: one-cycle pulse when a read byte was needed while `tx_valid` = 0.
- `busy` out 1: high from an address match until STOP.

## Operation
- **Edge detection:** SCL/SDA pass through the synchronizer and are then edge-detected. Rise/fall of the synchronized SCL are the bus events.
- **START:** SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- **Sampling and driving:** SDA is sampled on SCL rise. `sda_oe` changes only on SCL fall, or on reset.
- **States:** IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- **IDLE -> ADDR** on START.
- **ADDR:** shifts 8 bits MSB first (7-bit address plus R/W). At the 8th rise it compares the address with `SLAVE_ADDR`.
  - Match: go to ADDR_ACK and drive `sda_oe` = 1 at the next fall.
  - Mismatch: go to WAIT_STOP; the block never drives SDA.
- **ADDR_ACK:** holds the ACK for one SCL high phase. At the fall ending the ACK:
  - W: release SDA and go to WR_DATA.
  - R: load the shifter and go to RD_DATA.
- **WR_DATA:** shifts 8 bits. At the 8th rise it pulses `rx_valid`; `rx_first` is 1 for the first byte of the transfer. Then WR_ACK: always ACK, release at the next fall, back to WR_DATA.
- **Read byte load** (at the fall that starts each read byte):
  - `tx_valid` = 1: load `tx_data` and pulse `tx_ready`.
  - Otherwise: load 8'hFF and pulse `tx_underrun`.
- **RD_DATA:** `sda_oe` = ~bit, MSB first, updated at each fall.
- **RD_ACK:** SDA is released and the master ACK is sampled at the rise.
  - ACK (0): load the next byte at the next fall and return to RD_DATA.
  - NACK (1): go to WAIT_STOP.
- **STOP** in any state: go to IDLE, release SDA, `busy` = 0.
- **Repeated START** in any non-IDLE state: go to ADDR, clear the bit counter, release SDA.
- **Simultaneous STOP and SCL edge:** STOP wins.

## Timing
- **Reset values:** `sda_oe`, `rx_valid`, `rx_first`, `tx_ready`, `tx_underrun`, `busy` = 0; `rx_data` = 8'h00; state IDLE.
- **Reset mid-transfer:** SDA is released asynchronously, in the same cycle `areset` asserts.
- **Detection latency:** a bus edge is detected SYNC_STAGES+1 `pclk` after the wire changes.
- **`sda_oe` latency:** 1 `pclk` after fall detection.
- **`rx_valid` latency:** 1 `pclk` after detection of the 8th data rise.
- **`tx_ready`/`tx_underrun`:** asserted in the cycle the shifter loads.
- **Clock ratio:** `pclk` ≥ 16× SCL (≥ 6.4 MHz for 400 kHz).
- **Width rules:** 3-bit bit counter wraps 7 -> 0 per byte. The shifter is 8 bits, MSB first.

## Structure
- **Package `i2c_slave_pkg`:** state enum, `ACK` = 1'b0, `NACK` = 1'b1, `FILL_BYTE` = 8'hFF, `I2C_ADDR_W` = 7.
- **Sub-module `i2c_bus_sync`:** SYNC_STAGES synchronizer plus edge detect. Outputs `scl_rise`, `scl_fall`, `start_det`, `stop_det`.

## Test plan
- Write 0xD0 (addr 0x68, W), then 0xA5, 0x3C, STOP.
  - Required: ACKs on bits 9/18/27.
  - Required: `rx_valid` ×2, `rx_data` 0xA5 (`rx_first` = 1), then 0x3C (`rx_first` = 0).
  - Required: `busy` falls after STOP.
- Address 0x42 (0x84) write -> `sda_oe` never 1; `rx_valid` never pulses; IDLE after STOP.
- Read 0xD1 with `tx_data` = 0x5A, master NACKs -> SDA carries 0,1,0,1,1,0,1,0; `tx_ready` ×1; WAIT_STOP.
- Write 0xD0, 0x11, repeated START, 0xD1, read 2 bytes (0x01 ACK, 0x02 NACK) -> `rx_data` 0x11; `tx_ready` ×2; second address ACKed.
- Read with `tx_valid` = 0 -> byte 0xFF on bus, `tx_underrun` one pulse.
- `areset` asserted mid-read while `sda_oe` = 1 -> `sda_oe` = 0 the same cycle; the next START is decoded normally.
